// File: rtl/init_sequencer_if.sv
// Bring-up sequencer handshake bundle: engine start/done lines, rerun request and status.
// master = the side driving engines' done flags and rerun requests; slave = the sequencer.
interface init_sequencer_if #(
  parameter int NUM_STEPS = 4
);
  logic [NUM_STEPS-1:0] step_done;
  logic                 rerun_req;
  logic [3:0]           rerun_step;
  logic [NUM_STEPS-1:0] step_start;
  logic                 busy;
  logic                 seq_done;
  logic                 seq_error;
  logic [3:0]           cur_step;
  logic [1:0]           retry_cnt;
  logic [3:0]           state_out;

  modport master (
    output step_done, rerun_req, rerun_step,
    input  step_start, busy, seq_done, seq_error, cur_step, retry_cnt, state_out
  );

  modport slave (
    input  step_done, rerun_req, rerun_step,
    output step_start, busy, seq_done, seq_error, cur_step, retry_cnt, state_out
  );
endinterface

// File: rtl/init_sequencer.sv
// Power-up bring-up sequencer: startup delay, then gated one-hot start pulses to each engine.
// Define SEQ_RETRY_EN to retry a timed-out step up to MAX_RETRIES times before erroring.
module init_sequencer #(
  parameter int NUM_STEPS     = 4,
  parameter int DLY_W         = 32,
  parameter int STARTUP_DELAY = 250000,
  parameter int STEP_DELAY    = 100,
  parameter int TIMEOUT       = 100000,
  parameter int MAX_RETRIES   = 3
) (
  input  logic              clk_1us,
  input  logic              reset,
  init_sequencer_if.slave   ifc
);

  typedef enum logic [3:0] {
    S_STARTUP     = 4'd1,
    S_START       = 4'd2,
    S_WAIT        = 4'd3,
    S_DONE        = 4'd4,
    S_ERROR       = 4'd5,
    S_RERUN_START = 4'd6,
    S_RERUN_WAIT  = 4'd7
  } state_t;

  localparam logic [DLY_W-1:0] L_STARTUP_LAST = DLY_W'(STARTUP_DELAY - 1);
  localparam logic [DLY_W-1:0] L_STEP_MIN     = DLY_W'(STEP_DELAY - 1);
  localparam logic [DLY_W-1:0] L_TIMEOUT_LAST = DLY_W'(TIMEOUT - 1);
  localparam logic [3:0]       L_LAST_STEP    = 4'(NUM_STEPS - 1);
  localparam logic [4:0]       L_NUM_STEPS    = 5'(NUM_STEPS);
`ifdef SEQ_RETRY_EN
  localparam logic [1:0]       L_RETRY_LIMIT  = 2'(MAX_RETRIES);
`else
  // retry budget is zero when retries are compiled out
  localparam logic [1:0]       L_RETRY_LIMIT  = 2'(MAX_RETRIES) & 2'b00;
`endif

  state_t               r_state;
  logic [DLY_W-1:0]     r_tick;
  logic [3:0]           r_cur_step;
  logic [1:0]           r_retry_cnt;
  logic                 r_done_seen;
  logic [NUM_STEPS-1:0] r_step_start;
  logic                 r_busy;
  logic                 r_seq_done;
  logic                 r_seq_error;

  logic [NUM_STEPS-1:0] r_done_s1;
  logic [NUM_STEPS-1:0] r_done_ds;
  logic [NUM_STEPS-1:0] r_done_prev;
  logic                 r_rr_s1;
  logic                 r_rr_s2;
  logic                 r_rr_prev;

  logic [NUM_STEPS-1:0] w_done_rise;
  logic [15:0]          w_rise_pad;
  logic                 w_rise_cur;
  logic                 w_complete;
  logic                 w_timeout;
  logic                 w_rr_rise;
  logic                 w_rerun_ok;

  function automatic logic [NUM_STEPS-1:0] onehot(input logic [3:0] idx);
    logic [NUM_STEPS-1:0] o;
    for (int i = 0; i < NUM_STEPS; i++) begin
      o[i] = (idx == 4'(i));
    end
    return o;
  endfunction

  function automatic logic [DLY_W-1:0] tick_inc(input logic [DLY_W-1:0] t);
    return (t == {DLY_W{1'b1}}) ? t : t + {{(DLY_W-1){1'b0}}, 1'b1};
  endfunction

  // Two-flop synchronisers for the asynchronous engine flags and rerun request, plus edge history
  always_ff @(posedge clk_1us or negedge reset) begin
    if (!reset) begin
      r_done_s1   <= '0;
      r_done_ds   <= '0;
      r_done_prev <= '0;
      r_rr_s1     <= 1'b0;
      r_rr_s2     <= 1'b0;
      r_rr_prev   <= 1'b0;
    end else begin
      r_done_s1   <= ifc.step_done;
      r_done_ds   <= r_done_s1;
      r_done_prev <= r_done_ds;
      r_rr_s1     <= ifc.rerun_req;
      r_rr_s2     <= r_rr_s1;
      r_rr_prev   <= r_rr_s2;
    end
  end

  // Edge detection and step completion/timeout qualification
  always_comb begin
    w_done_rise = r_done_ds & ~r_done_prev;
    w_rise_pad  = 16'(w_done_rise);
    w_rise_cur  = w_rise_pad[r_cur_step];
    w_complete  = (r_done_seen | w_rise_cur) & (r_tick >= L_STEP_MIN);
    w_timeout   = (r_tick == L_TIMEOUT_LAST);
    w_rr_rise   = r_rr_s2 & ~r_rr_prev;
    w_rerun_ok  = ({1'b0, ifc.rerun_step} < L_NUM_STEPS);
  end

  // Sequencer FSM; outputs are set on the transition so step_start is high while in a START state
  always_ff @(posedge clk_1us or negedge reset) begin
    if (!reset) begin
      r_state      <= S_STARTUP;
      r_tick       <= '0;
      r_cur_step   <= 4'd0;
      r_retry_cnt  <= 2'd0;
      r_done_seen  <= 1'b0;
      r_step_start <= '0;
      r_busy       <= 1'b1;
      r_seq_done   <= 1'b0;
      r_seq_error  <= 1'b0;
    end else begin
      r_step_start <= '0;
      if (w_rise_cur) begin
        r_done_seen <= 1'b1;
      end
      case (r_state)
        S_STARTUP: begin
          if (r_tick == L_STARTUP_LAST) begin
            r_state      <= S_START;
            r_tick       <= '0;
            r_step_start <= onehot(r_cur_step);
          end else begin
            r_tick <= tick_inc(r_tick);
          end
        end
        S_START, S_RERUN_START: begin
          // a done level from before the pulse must not count, only a fresh edge
          r_done_seen <= 1'b0;
          r_tick      <= '0;
          r_state     <= (r_state == S_START) ? S_WAIT : S_RERUN_WAIT;
        end
        S_WAIT: begin
          if (w_complete) begin
            if (r_cur_step == L_LAST_STEP) begin
              r_state    <= S_DONE;
              r_busy     <= 1'b0;
              r_seq_done <= 1'b1;
            end else begin
              r_cur_step   <= r_cur_step + 4'd1;
              r_retry_cnt  <= 2'd0;
              r_state      <= S_START;
              r_step_start <= onehot(r_cur_step + 4'd1);
            end
          end else if (w_timeout) begin
            if (r_retry_cnt < L_RETRY_LIMIT) begin
              r_retry_cnt  <= r_retry_cnt + 2'd1;
              r_state      <= S_START;
              r_step_start <= onehot(r_cur_step);
            end else begin
              r_state     <= S_ERROR;
              r_busy      <= 1'b0;
              r_seq_error <= 1'b1;
            end
          end else begin
            r_tick <= tick_inc(r_tick);
          end
        end
        S_DONE: begin
          if (w_rr_rise && w_rerun_ok) begin
            r_cur_step   <= ifc.rerun_step;
            r_seq_done   <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= S_RERUN_START;
            r_step_start <= onehot(ifc.rerun_step);
          end else begin
            r_seq_done <= 1'b1;
          end
        end
        S_RERUN_WAIT: begin
          if (w_complete) begin
            r_state    <= S_DONE;
            r_busy     <= 1'b0;
            r_seq_done <= 1'b1;
          end else if (w_timeout) begin
            r_state     <= S_ERROR;
            r_busy      <= 1'b0;
            r_seq_error <= 1'b1;
          end else begin
            r_tick <= tick_inc(r_tick);
          end
        end
        S_ERROR: begin
          if (w_rr_rise) begin
            r_seq_error  <= 1'b0;
            r_cur_step   <= 4'd0;
            r_retry_cnt  <= 2'd0;
            r_tick       <= '0;
            r_busy       <= 1'b1;
            r_state      <= S_START;
            r_step_start <= onehot(4'd0);
          end else begin
            r_seq_error <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_STARTUP;
          r_tick      <= '0;
          r_cur_step  <= 4'd0;
          r_retry_cnt <= 2'd0;
          r_busy      <= 1'b1;
          r_seq_done  <= 1'b0;
          r_seq_error <= 1'b0;
        end
      endcase
    end
  end

  assign ifc.step_start = r_step_start;
  assign ifc.busy       = r_busy;
  assign ifc.seq_done   = r_seq_done;
  assign ifc.seq_error  = r_seq_error;
  assign ifc.cur_step   = r_cur_step;
  assign ifc.retry_cnt  = r_retry_cnt;
  assign ifc.state_out  = r_state;

endmodule

// File: tb/tb_init_sequencer.sv
// Bench for init_sequencer: table of engine-delay scenarios plus hand sequences for rerun,
// error recovery and mid-run reset. Start pulses are scoreboarded against a timing model.
module tb_init_sequencer;
  localparam int NS = 2;
`ifdef SEQ_RETRY_EN
  localparam int RETRIES = 2;
`else
  localparam int RETRIES = 0;
`endif

  logic clk_1us = 1'b0;
  logic reset   = 1'b0;

  init_sequencer_if #(.NUM_STEPS(NS)) ifc ();

  init_sequencer #(
    .NUM_STEPS(NS), .DLY_W(32), .STARTUP_DELAY(10), .STEP_DELAY(4),
    .TIMEOUT(20), .MAX_RETRIES(2)
  ) dut (
    .clk_1us(clk_1us),
    .reset  (reset),
    .ifc    (ifc)
  );

  always #5 clk_1us = ~clk_1us;

  typedef struct { int t; logic [NS-1:0] pat; } pulse_t;
  typedef struct { string name; int d0; int d1; bit stale0; } vec_t;

  pulse_t exp_q[$];
  pulse_t got_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int eng_delay[NS];
  bit eng_stale[NS];
  int eng_resp[NS];

  // cycles since reset release; value k seen between posedge k and posedge k+1
  always @(posedge clk_1us or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // engine model: drop done on start, raise it eng_delay cycles later (-1 = never)
  always @(negedge clk_1us) begin
    for (int i = 0; i < NS; i++) begin
      if (!reset) begin
        ifc.step_done[i] = eng_stale[i];
        eng_resp[i] = -1;
      end else if (ifc.step_start[i]) begin
        ifc.step_done[i] = eng_stale[i];
        eng_resp[i] = (eng_delay[i] < 0) ? -1 : cyc + eng_delay[i];
      end else if (cyc == eng_resp[i]) begin
        ifc.step_done[i] = 1'b1;
      end
    end
  end

  // observed start pulses
  always @(negedge clk_1us) begin
    if (reset === 1'b1 && ifc.step_start != '0) got_q.push_back('{cyc, ifc.step_start});
  end

  function automatic logic [31:0] outs();
    return {17'd0, ifc.step_start, ifc.busy, ifc.seq_done, ifc.seq_error,
            ifc.cur_step, ifc.retry_cnt, ifc.state_out};
  endfunction

  function automatic logic [31:0] mk(input logic b, input logic d, input logic e,
                                     input int cur, input int rc, input int st);
    return {17'd0, 2'b00, b, d, e, 4'(cur), 2'(rc), 4'(st)};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic wait_until(input int t, input string nm);
    int guard = 0;
    while (cyc < t && guard < 500) begin
      @(negedge clk_1us);
      guard++;
    end
    #1;
    if (cyc != t) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s wait: cycle %0d, expected %0d", nm, cyc, t);
    end
  endtask

  task automatic compare_pulses(input string nm);
    pulse_t e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (got_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s pulse missing: got none, expected %b at cycle %0d", nm, e.pat, e.t);
      end else begin
        g = got_q.pop_front();
        if (g.t != e.t || g.pat !== e.pat) begin
          n_fail++;
          $display("FAIL %s pulse: got %b at cycle %0d, expected %b at cycle %0d",
                   nm, g.pat, g.t, e.pat, e.t);
        end
      end
    end
    n_tests++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s extra pulse: got %b at cycle %0d, expected none",
               nm, got_q[0].pat, got_q[0].t);
      got_q.delete();
    end
  endtask

  // reset, configure engines, release, push expected pulses and check the end state
  task automatic run_vector(input vec_t v, output int t_end);
    int t, step, r, dl;
    bit err;
    logic [NS-1:0] p;
    @(negedge clk_1us);
    reset = 1'b0;
    ifc.rerun_req  = 1'b0;
    ifc.rerun_step = 4'd0;
    eng_delay[0] = v.d0;
    eng_delay[1] = v.d1;
    eng_stale[0] = v.stale0;
    eng_stale[1] = 1'b0;
    #1;
    check({v.name, " reset"}, outs(), mk(1'b1, 1'b0, 1'b0, 0, 0, 1));
    @(negedge clk_1us);
    @(negedge clk_1us);
    exp_q.delete();
    got_q.delete();
    t = 10; step = 0; r = 0; err = 1'b0;
    while (step < NS) begin
      p = 2'b01 << step;
      exp_q.push_back('{t, p});
      dl = (step == 0) ? v.d0 : v.d1;
      if (!(step == 0 && v.stale0) && dl >= 0 && dl <= 18) begin
        t = t + ((dl > 2) ? dl : 2) + 3;
        step++;
        r = 0;
      end else if (r < RETRIES) begin
        r++;
        t = t + 21;
      end else begin
        t = t + 21;
        err = 1'b1;
        break;
      end
    end
    reset = 1'b1;
    wait_until(t, v.name);
    if (err) check({v.name, " end"}, outs(), mk(1'b0, 1'b0, 1'b1, step, r, 5));
    else     check({v.name, " end"}, outs(), mk(1'b0, 1'b1, 1'b0, NS - 1, 0, 4));
    compare_pulses(v.name);
    t_end = t;
  endtask

  vec_t vecs[6];
  int   te;

  initial begin
    ifc.rerun_req  = 1'b0;
    ifc.rerun_step = 4'd0;
    vecs[0] = '{"nominal",       2,  2, 1'b0};
    vecs[1] = '{"slow0",         6,  2, 1'b0};
    vecs[2] = '{"edge_tick19",  18,  2, 1'b0};
    vecs[3] = '{"late_tick20",  19,  2, 1'b0};
    vecs[4] = '{"step1_dead",    2, -1, 1'b0};
    vecs[5] = '{"stale0",       -1,  2, 1'b1};
    for (int i = 0; i < 6; i++) run_vector(vecs[i], te);

    // rerun of step 1 from S_DONE, then an out-of-range rerun that must be ignored
    run_vector(vecs[0], te);
    wait_until(te + 2, "rerun");
    ifc.rerun_step = 4'd1;
    ifc.rerun_req  = 1'b1;
    exp_q.push_back('{te + 5, 2'b10});
    wait_until(te + 6, "rerun");
    check("rerun wait", outs(), mk(1'b1, 1'b0, 1'b0, 1, 0, 7));
    wait_until(te + 10, "rerun");
    check("rerun done", outs(), mk(1'b0, 1'b1, 1'b0, 1, 0, 4));
    ifc.rerun_req = 1'b0;
    wait_until(te + 14, "rerun");
    ifc.rerun_step = 4'd5;
    ifc.rerun_req  = 1'b1;
    wait_until(te + 26, "rerun");
    check("rerun bad idx", outs(), mk(1'b0, 1'b1, 1'b0, 1, 0, 4));
    compare_pulses("rerun");
    ifc.rerun_req = 1'b0;

    // error recovery: engine 0 healthy again, rerun_req restarts at step 0 without startup delay
    run_vector(vecs[5], te);
    eng_stale[0] = 1'b0;
    eng_delay[0] = 2;
    wait_until(te + 2, "recover");
    ifc.rerun_req = 1'b1;
    exp_q.push_back('{te + 5, 2'b01});
    exp_q.push_back('{te + 10, 2'b10});
    wait_until(te + 15, "recover");
    check("recover done", outs(), mk(1'b0, 1'b1, 1'b0, 1, 0, 4));
    compare_pulses("recover");
    ifc.rerun_req = 1'b0;

    // reset in the middle of step 1's wait, then full restart
    run_vector(vecs[0], te);
    @(negedge clk_1us);
    reset = 1'b0;
    @(negedge clk_1us);
    @(negedge clk_1us);
    got_q.delete();
    reset = 1'b1;
    exp_q.push_back('{10, 2'b01});
    exp_q.push_back('{15, 2'b10});
    wait_until(17, "midreset");
    check("midreset pre", outs(), mk(1'b1, 1'b0, 1'b0, 1, 0, 3));
    reset = 1'b0;
    #1;
    check("midreset async", outs(), mk(1'b1, 1'b0, 1'b0, 0, 0, 1));
    compare_pulses("midreset run1");
    @(negedge clk_1us);
    reset = 1'b1;
    exp_q.push_back('{10, 2'b01});
    exp_q.push_back('{15, 2'b10});
    wait_until(9, "midreset");
    check("midreset startup", outs(), mk(1'b1, 1'b0, 1'b0, 0, 0, 1));
    wait_until(20, "midreset");
    check("midreset end", outs(), mk(1'b0, 1'b1, 1'b0, 1, 0, 4));
    compare_pulses("midreset run2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/init_sequencer.md
Name: init_sequencer

Overview:
- Generic power-up bring-up sequencer clocked by the 1 us tick clock.
- After a startup delay, it issues one-cycle start pulses to NUM_STEPS peripheral init/config engines in order (ADV7513 init, camera init, register read-back, ...).
- Each step is gated on a minimum wait plus that engine's done edge, and guarded by a per-step timeout with optional retry.
- Status outputs drive LEDs/7-seg; supports a single-step rerun after completion.

Parameters:
- NUM_STEPS, 4, number of sequenced engines (1..16).
- DLY_W, 32, width of the tick counter.
- STARTUP_DELAY, 250000, clk_1us cycles spent in S_STARTUP before step 0.
- STEP_DELAY, 100, minimum clk_1us cycles from a start pulse to step completion.
- TIMEOUT, 100000, clk_1us cycles in S_WAIT before a timeout is declared. Must be > STEP_DELAY.
- MAX_RETRIES, 3, retries per step after a timeout (SEQ_RETRY_EN only).

Ports:
- clk_1us  in  1  1 MHz tick clock.
- reset  in  1  asynchronous, active-low.
- step_done  in  NUM_STEPS  level done flags from engines; asynchronous to clk_1us.
- rerun_req  in  1  request; synchronised internally (2FF).
- rerun_step  in  4  step index to rerun.
- step_start  out  NUM_STEPS  one-hot start pulse, one clk_1us cycle wide.
- busy  out  1  high in any state except S_DONE/S_ERROR.
- seq_done  out  1  whole sequence completed.
- seq_error  out  1  a step exhausted its attempts.
- cur_step  out  4  index of the active or failed step.
- retry_cnt  out  2  retries used on the current step.
- state_out  out  4  state encoding for 7-seg display.

Behaviour:
Reset (any time, including mid-operation):
- State S_STARTUP; tick=0; cur_step=0; retry_cnt=0.
- All outputs 0, except busy=1 and state_out=1.
- step_done passes through a 2FF synchroniser (ds). A rising edge on ds[cur_step] sets done_seen.

State encodings: S_STARTUP=1, S_START=2, S_WAIT=3, S_DONE=4, S_ERROR=5, S_RERUN_START=6, S_RERUN_WAIT=7.

S_STARTUP:
- tick increments.
- When tick==STARTUP_DELAY-1: go to S_START and clear tick.

S_START / S_RERUN_START:
- step_start[cur_step]=1 for exactly this cycle.
- done_seen cleared; tick cleared.
- Next state is the matching WAIT state.

S_WAIT:
- tick increments.
- Completion = done_seen (or a rising edge this cycle) AND tick>=STEP_DELAY-1.
- On completion with cur_step==NUM_STEPS-1: go to S_DONE.
- On completion otherwise: cur_step+1, retry_cnt=0, go to S_START.
- A level held high from before the start pulse never counts; an edge is required.
- Timeout: tick==TIMEOUT-1 without completion. Handled per the optional feature.
- Completion and timeout in the same cycle: completion wins.

S_DONE:
- seq_done=1 is held.
- rerun_req rising edge with rerun_step<NUM_STEPS: cur_step=rerun_step, seq_done=0, go to S_RERUN_START.
- rerun_step>=NUM_STEPS is ignored.

S_RERUN_WAIT:
- Same completion rule as S_WAIT.
- Completion returns to S_DONE with seq_done=1.
- Timeout goes to S_ERROR.

S_ERROR:
- seq_error=1; cur_step holds the failing index.
- rerun_req rising edge: clear error, cur_step=0, retry_cnt=0, go to S_START (no startup delay).

General rules:
- rerun_req in any other state is ignored.
- Counters saturate and never wrap.
- Outputs are registered; step_start has zero latency relative to entering the START state.

Optional Feature:
SEQ_RETRY_EN
- Defined: a timeout in S_WAIT with retry_cnt<MAX_RETRIES increments retry_cnt and returns to S_START for the same step. At retry_cnt==MAX_RETRIES, go to S_ERROR.
- Undefined: any S_WAIT timeout goes directly to S_ERROR; retry_cnt stays 0.
- Rerun path: never retries.

Test Plan:
Bench config for all scenarios: NUM_STEPS=2, STARTUP_DELAY=10, STEP_DELAY=4, TIMEOUT=20, MAX_RETRIES=2.
1. Nominal: engines raise done 2 cycles after each start.
   - step_start=01 exactly 10 cycles after reset release.
   - step_start=10 one cycle after step 0's min-delay completion (≥4 cycles after the first pulse).
   - Then seq_done=1, busy=0, state_out=4.
2. Stale done: step_done[0] held high from reset → no completion; a timeout is declared at tick 19.
3. Step 1 never responds, SEQ_RETRY_EN defined → three step_start=10 pulses, then seq_error=1, cur_step=1, retry_cnt=2. Without the macro → one pulse, then seq_error=1, retry_cnt=0.
4. From S_DONE, rerun_req with rerun_step=1 → single step_start=10 pulse, seq_done=0 during the wait, then seq_done=1. A request with rerun_step=5 → no pulse.
5. Reset asserted mid S_WAIT → outputs immediately 0 (busy=1, state_out=1); the sequence restarts with the full 10-cycle startup delay.
6. done edge arrives on cycle tick==19 → step completes, with no retry and no error.
